// File: rtl/forwarding_unit_pkg.sv
// Shared constants for the EX-stage operand forwarding logic.
// Select encodings drive the ALU operand muxes; 2'b11 is never produced.
package forwarding_unit_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b01;
  localparam logic [1:0] FWD_MEMWB   = 2'b10;

endpackage

// File: rtl/forwarding_unit_fwd_select.sv
// Per-operand forwarding decision: picks the youngest in-flight writer of rs.
// Register 0 is hardwired to zero, so a write to it is never forwarded.
module fwd_select #(
  parameter int REG_ADDR_W = forwarding_unit_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] ex_mem_rd,
  input  logic                  ex_mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_wb_rd,
  input  logic                  mem_wb_reg_write,
  output logic [1:0]            sel
);
  import forwarding_unit_pkg::*;

  logic ex_mem_hit;
  logic mem_wb_hit;

  assign ex_mem_hit = ex_mem_reg_write && (ex_mem_rd != '0) && (ex_mem_rd == rs);
  assign mem_wb_hit = mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == rs);

  // EX/MEM holds the newer value, so it wins when both stages match.
  always_comb begin
    sel = FWD_REGFILE;
    if (ex_mem_hit) begin
      sel = FWD_EXMEM;
    end else if (mem_wb_hit) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/forwarding_unit.sv
// Operand forwarding unit: combinational mux selects for both EX operands
// plus saturating counters of how often each forwarding path is used.
module forwarding_unit #(
  parameter int REG_ADDR_W = forwarding_unit_pkg::REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] idExRs,
  input  logic [REG_ADDR_W-1:0] idExRt,
  input  logic [REG_ADDR_W-1:0] exMemRd,
  input  logic                  exMemRegWrite,
  input  logic [REG_ADDR_W-1:0] memWbRd,
  input  logic                  memWbRegWrite,
  output logic [1:0]            operand1Control,
  output logic [1:0]            operand2Control,
  output logic [CNT_W-1:0]      exMemFwdCount,
  output logic [CNT_W-1:0]      memWbFwdCount
);
  import forwarding_unit_pkg::*;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  logic [1:0]       op1_raw;
  logic [1:0]       op2_raw;
  logic [1:0]       exmem_inc;
  logic [1:0]       memwb_inc;
  logic [CNT_W-1:0] exmem_cnt_p0;
  logic [CNT_W-1:0] memwb_cnt_p0;

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_sel_op1 (
    .rs               (idExRs),
    .ex_mem_rd        (exMemRd),
    .ex_mem_reg_write (exMemRegWrite),
    .mem_wb_rd        (memWbRd),
    .mem_wb_reg_write (memWbRegWrite),
    .sel              (op1_raw)
  );

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_sel_op2 (
    .rs               (idExRt),
    .ex_mem_rd        (exMemRd),
    .ex_mem_reg_write (exMemRegWrite),
    .mem_wb_rd        (memWbRd),
    .mem_wb_reg_write (memWbRegWrite),
    .sel              (op2_raw)
  );

  // Reset gates the selects immediately, without waiting for a clock edge.
  assign operand1Control = reset ? FWD_REGFILE : op1_raw;
  assign operand2Control = reset ? FWD_REGFILE : op2_raw;

  always_comb begin
    exmem_inc = {1'b0, operand1Control == FWD_EXMEM} + {1'b0, operand2Control == FWD_EXMEM};
    memwb_inc = {1'b0, operand1Control == FWD_MEMWB} + {1'b0, operand2Control == FWD_MEMWB};
  end

  // Stage p0: per-cycle event accumulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      exmem_cnt_p0 <= '0;
      memwb_cnt_p0 <= '0;
    end else begin
      exmem_cnt_p0 <= sat_add(exmem_cnt_p0, exmem_inc);
      memwb_cnt_p0 <= sat_add(memwb_cnt_p0, memwb_inc);
    end
  end

  assign exMemFwdCount = exmem_cnt_p0;
  assign memWbFwdCount = memwb_cnt_p0;

endmodule

// File: tb/tb_forwarding_unit.sv
// Scoreboard bench for forwarding_unit: a 16-bit and a 4-bit counter instance
// share stimulus; the driver queues expectations, the monitor checks them.
module tb_forwarding_unit;

  typedef struct {
    logic [1:0]  op1;
    logic [1:0]  op2;
    int unsigned ex16;
    int unsigned wb16;
    int unsigned ex4;
    int unsigned wb4;
    string       tag;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [4:0] idExRs, idExRt, exMemRd, memWbRd;
  logic       exMemRegWrite, memWbRegWrite;
  logic [1:0] op1_a, op2_a, op1_b, op2_b;
  logic [15:0] ex_a, wb_a;
  logic [3:0]  ex_b, wb_b;

  exp_t        sb[$];
  int          checks = 0;
  int          fails = 0;
  int unsigned m_ex16 = 0, m_wb16 = 0, m_ex4 = 0, m_wb4 = 0;

  forwarding_unit dut_a (
    .clk(clk), .reset(reset),
    .idExRs(idExRs), .idExRt(idExRt),
    .exMemRd(exMemRd), .exMemRegWrite(exMemRegWrite),
    .memWbRd(memWbRd), .memWbRegWrite(memWbRegWrite),
    .operand1Control(op1_a), .operand2Control(op2_a),
    .exMemFwdCount(ex_a), .memWbFwdCount(wb_a)
  );

  forwarding_unit #(.REG_ADDR_W(5), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset),
    .idExRs(idExRs), .idExRt(idExRt),
    .exMemRd(exMemRd), .exMemRegWrite(exMemRegWrite),
    .memWbRd(memWbRd), .memWbRegWrite(memWbRegWrite),
    .operand1Control(op1_b), .operand2Control(op2_b),
    .exMemFwdCount(ex_b), .memWbFwdCount(wb_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference rule: newest writer of a nonzero register wins.
  function automatic logic [1:0] ref_sel(input logic [4:0] src,
                                         input logic [4:0] exrd, input logic exw,
                                         input logic [4:0] wbrd, input logic wbw);
    if (exw && exrd != 0 && exrd == src) return 2'b01;
    if (wbw && wbrd != 0 && wbrd == src) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int unsigned ref_cnt(input int unsigned c, input int unsigned n,
                                          input int unsigned maxv);
    return (c + n > maxv) ? maxv : c + n;
  endfunction

  task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] exrd, input logic exw,
                      input logic [4:0] wbrd, input logic wbw, input string tag);
    exp_t e;
    int unsigned n_ex, n_wb;
    @(negedge clk);
    reset = rst; idExRs = rs; idExRt = rt;
    exMemRd = exrd; exMemRegWrite = exw; memWbRd = wbrd; memWbRegWrite = wbw;
    e.op1 = rst ? 2'b00 : ref_sel(rs, exrd, exw, wbrd, wbw);
    e.op2 = rst ? 2'b00 : ref_sel(rt, exrd, exw, wbrd, wbw);
    n_ex = (e.op1 == 2'b01 ? 1 : 0) + (e.op2 == 2'b01 ? 1 : 0);
    n_wb = (e.op1 == 2'b10 ? 1 : 0) + (e.op2 == 2'b10 ? 1 : 0);
    if (rst) begin
      m_ex16 = 0; m_wb16 = 0; m_ex4 = 0; m_wb4 = 0;
    end else begin
      m_ex16 = ref_cnt(m_ex16, n_ex, 65535);
      m_wb16 = ref_cnt(m_wb16, n_wb, 65535);
      m_ex4  = ref_cnt(m_ex4, n_ex, 15);
      m_wb4  = ref_cnt(m_wb4, n_wb, 15);
    end
    e.ex16 = m_ex16; e.wb16 = m_wb16; e.ex4 = m_ex4; e.wb4 = m_wb4;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input string tag,
                     input int unsigned act, input int unsigned req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s [%s]: got %0d, expected %0d", name, tag, act, req);
    end
  endtask

  // Monitor: inputs stay stable from negedge to negedge, so 1 time unit after
  // the rising edge shows both the combinational selects and updated counters.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("op1_cnt16", e.tag, int'(op1_a), int'(e.op1));
        chk("op2_cnt16", e.tag, int'(op2_a), int'(e.op2));
        chk("op1_cnt4",  e.tag, int'(op1_b), int'(e.op1));
        chk("op2_cnt4",  e.tag, int'(op2_b), int'(e.op2));
        chk("exmem_cnt16", e.tag, int'(ex_a), e.ex16);
        chk("memwb_cnt16", e.tag, int'(wb_a), e.wb16);
        chk("exmem_cnt4",  e.tag, int'(ex_b), e.ex4);
        chk("memwb_cnt4",  e.tag, int'(wb_b), e.wb4);
      end
    end
  end

  initial begin
    int waited;
    reset = 1'b1; idExRs = 0; idExRt = 0; exMemRd = 0; memWbRd = 0;
    exMemRegWrite = 0; memWbRegWrite = 0;

    step(1, 5'd4, 5'd4, 5'd4, 1, 5'd4, 1, "reset_state");
    step(1, 5'd0, 5'd0, 5'd0, 0, 5'd0, 0, "reset_idle");

    step(0, 5'd4, 5'd4, 5'd7, 1, 5'd4, 1, "rs4_rt4_wb");
    step(0, 5'd4, 5'd7, 5'd7, 1, 5'd4, 1, "rt7");
    step(0, 5'd4, 5'd7, 5'd4, 1, 5'd4, 1, "exrd4_priority");
    step(0, 5'd4, 5'd7, 5'd4, 1, 5'd7, 1, "wbrd7");
    step(0, 5'd9, 5'd9, 5'd9, 0, 5'd9, 0, "no_regwrite");
    step(0, 5'd0, 5'd0, 5'd0, 1, 5'd0, 1, "reg0_never");

    step(1, 5'd0, 5'd0, 5'd0, 0, 5'd0, 0, "pre_reset");
    for (int i = 0; i < 3; i++) step(0, 5'd3, 5'd5, 5'd3, 1, 5'd5, 1, "op1ex_op2wb");
    step(1, 5'd3, 5'd5, 5'd3, 1, 5'd5, 1, "mid_reset");
    step(0, 5'd3, 5'd5, 5'd3, 1, 5'd5, 1, "after_reset");

    step(1, 5'd0, 5'd0, 5'd0, 0, 5'd0, 0, "sat_reset");
    for (int i = 0; i < 10; i++) step(0, 5'd6, 5'd6, 5'd6, 1, 5'd2, 1, "sat_both_ex");

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(39) == 0) ? 1'b1 : 1'b0,
           5'($urandom_range(3)), 5'($urandom_range(3)),
           5'($urandom_range(3)), 1'($urandom_range(1)),
           5'($urandom_range(3)), 1'($urandom_range(1)), "random");
    end

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (sb.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
